// File: rtl/sram_1r1w_init_sweep_if.sv
// Port bundle for the 1R1W SRAM with clear sweep: read port, masked write port,
// sweep request and the ready status.
interface sram_1r1w_init_sweep_if #(
    parameter int unsigned WIDTH    = 6,
    parameter int unsigned AW       = 8,
    parameter int unsigned MASK_SEG = 1
);
    logic                R0_en;
    logic [AW-1:0]       R0_addr;
    logic [WIDTH-1:0]    R0_data;
    logic                W0_en;
    logic [AW-1:0]       W0_addr;
    logic [WIDTH-1:0]    W0_data;
    logic [MASK_SEG-1:0] W0_mask;
    logic                init_req;
    logic                ready;

    modport master (
        output R0_en, R0_addr, W0_en, W0_addr, W0_data, W0_mask, init_req,
        input  R0_data, ready
    );

    modport slave (
        input  R0_en, R0_addr, W0_en, W0_addr, W0_data, W0_mask, init_req,
        output R0_data, ready
    );
endinterface

// File: rtl/sram_1r1w_init_sweep.sv
// 1-read/1-write synchronous SRAM with segmented write mask, selectable
// read-during-write forwarding and a clear sweep after reset or on request.
module sram_1r1w_init_sweep #(
    parameter int unsigned      DEPTH    = 256,
    parameter int unsigned      WIDTH    = 6,
    parameter int unsigned      MASK_SEG = 1,
    parameter int unsigned      BYPASS   = 1,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    sram_1r1w_init_sweep_if.slave    bus
);
    localparam int unsigned AW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned G  = WIDTH / MASK_SEG;
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    if (DEPTH < 2) begin : g_bad_depth
        $error("sram_1r1w_init_sweep: DEPTH must be at least 2");
    end
    if ((WIDTH % MASK_SEG) != 0) begin : g_bad_mask
        $error("sram_1r1w_init_sweep: WIDTH must be a multiple of MASK_SEG");
    end

    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic [WIDTH-1:0] ram [DEPTH];

    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic [WIDTH-1:0] ram_wbits;

    logic             r_in_range;
    logic             w_in_range;
    logic             rdw_hit;
    logic [WIDTH-1:0] seg_bits;
    logic [WIDTH-1:0] rd_old;
    logic [WIDTH-1:0] rd_word;

    assign r_in_range = ({1'b0, bus.R0_addr} < DEPTH_W);
    assign w_in_range = ({1'b0, bus.W0_addr} < DEPTH_W);
    assign rdw_hit    = (BYPASS != 0) && bus.W0_en && w_in_range && r_in_range
                        && (bus.R0_addr == bus.W0_addr);

    // Expand the per-segment write mask into a per-bit mask.
    always_comb begin
        seg_bits = '0;
        for (int k = 0; k < int'(MASK_SEG); k++) begin
            seg_bits[k*G +: G] = {G{bus.W0_mask[k]}};
        end
    end

    // Out-of-range reads return the sweep value; same-address writes forward per segment.
    always_comb begin
        rd_old  = r_in_range ? ram[bus.R0_addr] : INIT_VAL;
        rd_word = rd_old;
        if (rdw_hit) begin
            rd_word = (rd_old & ~seg_bits) | (bus.W0_data & seg_bits);
        end
    end

    // Next state, sweep counter, array write port and read capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        rdata_d   = rdata_q;
        ram_we    = 1'b0;
        ram_waddr = cnt_q;
        ram_wdata = INIT_VAL;
        ram_wbits = '1;

        case (state_q)
            SWEEP: begin
                ram_we = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = READY;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            READY: begin
                if (bus.W0_en && w_in_range) begin
                    ram_we    = 1'b1;
                    ram_waddr = bus.W0_addr;
                    ram_wdata = bus.W0_data;
                    ram_wbits = seg_bits;
                end
                if (bus.R0_en) begin
                    rdata_d = rd_word;
                end
                // Port operations of this cycle still complete before the sweep starts.
                if (bus.init_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    // Array storage is deliberately not reset; the sweep defines its contents.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram[ram_waddr] <= (ram[ram_waddr] & ~ram_wbits) | (ram_wdata & ram_wbits);
        end
    end

    assign bus.R0_data = rdata_q;
    assign bus.ready   = ready_q;
endmodule

// File: tb/tb_sram_1r1w_init_sweep.sv
// Bench for sram_1r1w_init_sweep: randomized traffic against an array model,
// a vector table for masking/forwarding, and sequences for re-init and reset.
module tb_sram_1r1w_init_sweep;
    logic clk = 1'b0;
    logic rst0 = 1'b0;
    logic rst12 = 1'b0;
    logic rst3 = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sram_1r1w_init_sweep_if #(.WIDTH(6),  .AW(8), .MASK_SEG(1)) if0 ();
    sram_1r1w_init_sweep_if #(.WIDTH(16), .AW(4), .MASK_SEG(2)) if1 ();
    sram_1r1w_init_sweep_if #(.WIDTH(16), .AW(4), .MASK_SEG(2)) if2 ();
    sram_1r1w_init_sweep_if #(.WIDTH(6),  .AW(7), .MASK_SEG(1)) if3 ();

    sram_1r1w_init_sweep #(.DEPTH(256), .WIDTH(6), .MASK_SEG(1), .BYPASS(1), .INIT_VAL(6'h15))
        u0 (.clock(clk), .reset_n(rst0), .bus(if0));
    sram_1r1w_init_sweep #(.DEPTH(12), .WIDTH(16), .MASK_SEG(2), .BYPASS(1), .INIT_VAL(16'h00C3))
        u1 (.clock(clk), .reset_n(rst12), .bus(if1));
    sram_1r1w_init_sweep #(.DEPTH(12), .WIDTH(16), .MASK_SEG(2), .BYPASS(0), .INIT_VAL(16'h00C3))
        u2 (.clock(clk), .reset_n(rst12), .bus(if2));
    sram_1r1w_init_sweep #(.DEPTH(100), .WIDTH(6), .MASK_SEG(1), .BYPASS(1), .INIT_VAL(6'h0A))
        u3 (.clock(clk), .reset_n(rst3), .bus(if3));

    typedef struct {
        logic        re;
        logic [3:0]  ra;
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [1:0]  wm;
        logic [15:0] exp_b1;
        logic [15:0] exp_b0;
    } vec_t;

    vec_t tbl [13];

    // Reference model for u0: word array, last read value, sweep progress.
    logic [5:0] m_mem [256];
    logic [5:0] m_rd = '0;
    bit         m_rdy = 1'b0;
    int         m_sw = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle on u0, advance the model by the same edge, compare.
    task automatic step0(input logic re, input logic [7:0] ra, input logic we,
                         input logic [7:0] wa, input logic [5:0] wd, input logic wm,
                         input logic ir);
        if0.R0_en = re; if0.R0_addr = ra;
        if0.W0_en = we; if0.W0_addr = wa; if0.W0_data = wd; if0.W0_mask = wm;
        if0.init_req = ir;
        if (m_rdy) begin
            if (re) m_rd = (we && wm && (wa == ra)) ? wd : m_mem[ra];
            if (we && wm) m_mem[wa] = wd;
            if (ir) begin
                m_rdy = 1'b0;
                m_sw  = 0;
            end
        end else begin
            m_sw++;
            if (m_sw == 256) begin
                m_rdy = 1'b1;
                for (int i = 0; i < 256; i++) m_mem[i] = 6'h15;
            end
        end
        tick();
        check("u0_ready", 32'(if0.ready), 32'(m_rdy));
        check("u0_rdata", 32'(if0.R0_data), 32'(m_rd));
    endtask

    task automatic idle0();
        step0(1'b0, 8'd0, 1'b0, 8'd0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic drive3(input logic re, input logic [6:0] ra, input logic we,
                          input logic [6:0] wa, input logic [5:0] wd);
        if3.R0_en = re; if3.R0_addr = ra;
        if3.W0_en = we; if3.W0_addr = wa; if3.W0_data = wd; if3.W0_mask = 1'b1;
        if3.init_req = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        //                  re  ra     we  wa     wd        wm     BYPASS=1  BYPASS=0
        tbl[0]  = '{1'b0, 4'd0,  1'b1, 4'd3,  16'h0000, 2'b11, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 4'd0,  1'b1, 4'd7,  16'hABCD, 2'b11, 16'h0000, 16'h0000};
        tbl[2]  = '{1'b0, 4'd0,  1'b1, 4'd7,  16'h1234, 2'b01, 16'h0000, 16'h0000};
        tbl[3]  = '{1'b1, 4'd7,  1'b0, 4'd0,  16'h0000, 2'b00, 16'hAB34, 16'hAB34};
        tbl[4]  = '{1'b1, 4'd3,  1'b1, 4'd3,  16'hFFFF, 2'b10, 16'hFF00, 16'h0000};
        tbl[5]  = '{1'b1, 4'd3,  1'b0, 4'd0,  16'h0000, 2'b00, 16'hFF00, 16'hFF00};
        tbl[6]  = '{1'b1, 4'd14, 1'b1, 4'd14, 16'hBEEF, 2'b11, 16'h00C3, 16'h00C3};
        tbl[7]  = '{1'b1, 4'd11, 1'b0, 4'd0,  16'h0000, 2'b00, 16'h00C3, 16'h00C3};
        tbl[8]  = '{1'b0, 4'd7,  1'b1, 4'd7,  16'h0000, 2'b11, 16'h00C3, 16'h00C3};
        tbl[9]  = '{1'b1, 4'd7,  1'b0, 4'd0,  16'h0000, 2'b00, 16'h0000, 16'h0000};
        tbl[10] = '{1'b1, 4'd2,  1'b1, 4'd5,  16'h1111, 2'b11, 16'h00C3, 16'h00C3};
        tbl[11] = '{1'b1, 4'd5,  1'b0, 4'd0,  16'h0000, 2'b00, 16'h1111, 16'h1111};
        tbl[12] = '{1'b1, 4'd5,  1'b1, 4'd5,  16'hFFFF, 2'b00, 16'h1111, 16'h1111};

        if0.R0_en = 0; if0.R0_addr = '0; if0.W0_en = 0; if0.W0_addr = '0;
        if0.W0_data = '0; if0.W0_mask = '0; if0.init_req = 0;
        if1.R0_en = 0; if1.R0_addr = '0; if1.W0_en = 0; if1.W0_addr = '0;
        if1.W0_data = '0; if1.W0_mask = '0; if1.init_req = 0;
        if2.R0_en = 0; if2.R0_addr = '0; if2.W0_en = 0; if2.W0_addr = '0;
        if2.W0_data = '0; if2.W0_mask = '0; if2.init_req = 0;
        if3.R0_en = 0; if3.R0_addr = '0; if3.W0_en = 0; if3.W0_addr = '0;
        if3.W0_data = '0; if3.W0_mask = '0; if3.init_req = 0;

        repeat (3) tick();
        check("rst_u0_ready", 32'(if0.ready), 32'd0);
        check("rst_u0_rdata", 32'(if0.R0_data), 32'd0);
        check("rst_u3_ready", 32'(if3.ready), 32'd0);

        // Post-reset sweep under random traffic: nothing may leak through.
        rst0 = 1'b1;
        rst12 = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            step0(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                  6'($urandom), 1'($urandom), 1'($urandom));
            check("sweep_ready", 32'(if0.ready), 32'(i == 256));
            check("sweep_rdata", 32'(if0.R0_data), 32'd0);
        end
        for (int i = 0; i < 256; i++) begin
            step0(1'b1, 8'(i), 1'b0, 8'd0, 6'd0, 1'b0, 1'b0);
            check("sweep_value", 32'(if0.R0_data), 32'h15);
        end

        // Masking and read-during-write on both forwarding variants.
        for (int i = 0; i < 13; i++) begin
            if1.R0_en = tbl[i].re; if1.R0_addr = tbl[i].ra;
            if1.W0_en = tbl[i].we; if1.W0_addr = tbl[i].wa;
            if1.W0_data = tbl[i].wd; if1.W0_mask = tbl[i].wm;
            if2.R0_en = tbl[i].re; if2.R0_addr = tbl[i].ra;
            if2.W0_en = tbl[i].we; if2.W0_addr = tbl[i].wa;
            if2.W0_data = tbl[i].wd; if2.W0_mask = tbl[i].wm;
            tick();
            check($sformatf("vec%0d_byp1", i), 32'(if1.R0_data), 32'(tbl[i].exp_b1));
            check($sformatf("vec%0d_byp0", i), 32'(if2.R0_data), 32'(tbl[i].exp_b0));
            check($sformatf("vec%0d_ready", i), 32'(if1.ready & if2.ready), 32'd1);
        end
        if1.R0_en = 0; if1.W0_en = 0; if2.R0_en = 0; if2.W0_en = 0;

        // Random traffic with occasional re-init requests.
        for (int i = 0; i < 600; i++) begin
            step0(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                  6'($urandom), 1'($urandom), ($urandom_range(0, 63) == 0));
        end
        n = 0;
        while (!m_rdy && n < 300) begin
            idle0();
            n++;
        end
        check("drain_ready", 32'(m_rdy), 32'd1);

        // Re-init: the request cycle still reads, then a full sweep follows.
        step0(1'b0, 8'd0, 1'b1, 8'd10, 6'h3F, 1'b1, 1'b0);
        step0(1'b1, 8'd10, 1'b0, 8'd0, 6'd0, 1'b0, 1'b1);
        check("reinit_rdata", 32'(if0.R0_data), 32'h3F);
        check("reinit_ready", 32'(if0.ready), 32'd0);
        for (int j = 1; j <= 256; j++) begin
            idle0();
            check("reinit_len", 32'(if0.ready), 32'(j == 256));
        end
        step0(1'b1, 8'd10, 1'b0, 8'd0, 6'd0, 1'b0, 1'b0);
        check("reinit_cleared", 32'(if0.R0_data), 32'h15);

        // Hold: an unread write must not disturb the captured data.
        step0(1'b0, 8'd0, 1'b1, 8'd5, 6'h2A, 1'b1, 1'b0);
        step0(1'b1, 8'd5, 1'b0, 8'd0, 6'd0, 1'b0, 1'b0);
        check("hold_first", 32'(if0.R0_data), 32'h2A);
        step0(1'b0, 8'd5, 1'b1, 8'd5, 6'h01, 1'b1, 1'b0);
        check("hold_after_wr", 32'(if0.R0_data), 32'h2A);
        idle0();
        idle0();
        check("hold_idle", 32'(if0.R0_data), 32'h2A);
        step0(1'b1, 8'd5, 1'b0, 8'd0, 6'd0, 1'b0, 1'b0);
        check("hold_reread", 32'(if0.R0_data), 32'h01);

        // Non-power-of-two depth with a reset landing mid-sweep.
        rst3 = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            check("d100_pre_ready", 32'(if3.ready), 32'd0);
        end
        rst3 = 1'b0;
        #1;
        check("d100_rst_ready", 32'(if3.ready), 32'd0);
        check("d100_rst_rdata", 32'(if3.R0_data), 32'd0);
        tick();
        rst3 = 1'b1;
        for (int j = 1; j <= 100; j++) begin
            tick();
            check("d100_ready", 32'(if3.ready), 32'(j == 100));
        end
        drive3(1'b0, 7'd0, 1'b1, 7'd120, 6'h3F);
        drive3(1'b1, 7'd120, 1'b0, 7'd0, 6'd0);
        check("d100_oob_read", 32'(if3.R0_data), 32'h0A);
        drive3(1'b1, 7'd56, 1'b0, 7'd0, 6'd0);
        check("d100_alias", 32'(if3.R0_data), 32'h0A);
        for (int i = 0; i < 100; i++) begin
            drive3(1'b1, 7'(i), 1'b0, 7'd0, 6'd0);
            check("d100_scan", 32'(if3.R0_data), 32'h0A);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
